// File: rtl/lfsr_share_ctrl.sv
// lfsr_share_ctrl: one 13-bit Fibonacci LFSR shared by NREQ requesters.
// A refresh interval of REFRESH shifts separates grants; each grant
// delivers one registered random word on rnd_out.
// Ports: clock, reset (async, active high), enable (global run),
//   req[NREQ] (level requests), seed_load/seed_val (reseed),
//   gnt[NREQ] (one-hot pulse), rnd_out[13], ready (in READY state).
// Option: define LFSR_SHARE_RR_EN for round-robin arbitration;
//   without it req[0] has fixed highest priority.
module lfsr_share_ctrl #(
    parameter int          NREQ    = 4,
    parameter int          REFRESH = 13,
    parameter logic [12:0] SEED    = 13'h000F
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic [NREQ-1:0] req,
    input  logic            seed_load,
    input  logic [12:0]     seed_val,
    output logic [NREQ-1:0] gnt,
    output logic [12:0]     rnd_out,
    output logic            ready
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic {
        REFILL = 1'b0,
        READY  = 1'b1
    } st_t;

    st_t             st_q, st_d;
    logic [12:0]     lfsr_q, lfsr_d;
    logic [12:0]     rnd_q, rnd_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q;

    logic            fb;
    logic [12:0]     lfsr_nxt;
    logic            hit;
    logic [PW-1:0]   win;
    logic [PW:0]     scan;

`ifdef LFSR_SHARE_RR_EN
    logic [PW-1:0]   ptr_d;
`else
    // Fixed priority: search always starts at requester 0.
    assign ptr_q = '0;
`endif

    assign fb       = lfsr_q[12] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
    assign lfsr_nxt = {lfsr_q[11:0], fb};

    // Search upward from ptr_q with wrap; first set req wins.
    always_comb begin
        hit  = 1'b0;
        win  = '0;
        scan = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(NREQ)) begin
                scan = scan - (PW+1)'(NREQ);
            end
            if (!hit && req[scan[PW-1:0]]) begin
                hit = 1'b1;
                win = scan[PW-1:0];
            end
        end
    end

    always_comb begin
        st_d   = st_q;
        lfsr_d = lfsr_q;
        rnd_d  = rnd_q;
        cnt_d  = cnt_q;
        gnt_d  = '0;
`ifdef LFSR_SHARE_RR_EN
        ptr_d  = ptr_q;
`endif
        if (seed_load) begin
            // Zero would lock the LFSR, so fall back to the default seed.
            lfsr_d = (seed_val == 13'h0) ? 13'h000F : seed_val;
            cnt_d  = 4'd0;
            st_d   = REFILL;
        end else if (enable) begin
            lfsr_d = lfsr_nxt;
            unique case (st_q)
                REFILL: begin
                    if (cnt_q == 4'(REFRESH-1)) begin
                        st_d  = READY;
                        cnt_d = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                READY: begin
                    if (hit) begin
                        gnt_d[win] = 1'b1;
                        rnd_d      = lfsr_q;
                        st_d       = REFILL;
`ifdef LFSR_SHARE_RR_EN
                        if (win == PW'(NREQ-1)) begin
                            ptr_d = '0;
                        end else begin
                            ptr_d = win + PW'(1);
                        end
`endif
                    end
                end
                default: begin
                    st_d = REFILL;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q   <= REFILL;
            lfsr_q <= SEED;
            rnd_q  <= 13'h0;
            cnt_q  <= 4'd0;
            gnt_q  <= '0;
`ifdef LFSR_SHARE_RR_EN
            ptr_q  <= '0;
`endif
        end else begin
            st_q   <= st_d;
            lfsr_q <= lfsr_d;
            rnd_q  <= rnd_d;
            cnt_q  <= cnt_d;
            gnt_q  <= gnt_d;
`ifdef LFSR_SHARE_RR_EN
            ptr_q  <= ptr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign rnd_out = rnd_q;
    assign ready   = (st_q == READY);

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Testbench for lfsr_share_ctrl: directed vector table, hand-written
// round-robin/reset sequences and a randomized run against a model.
module tb_lfsr_share_ctrl;

    localparam int NREQ    = 4;
    localparam int REFRESH = 13;

    logic            clock;
    logic            reset;
    logic            enable;
    logic [NREQ-1:0] req;
    logic            seed_load;
    logic [12:0]     seed_val;
    logic [NREQ-1:0] gnt;
    logic [12:0]     rnd_out;
    logic            ready;

    int checks = 0;
    int errors = 0;

    lfsr_share_ctrl #(
        .NREQ(NREQ),
        .REFRESH(REFRESH),
        .SEED(13'h000F)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .req(req),
        .seed_load(seed_load),
        .seed_val(seed_val),
        .gnt(gnt),
        .rnd_out(rnd_out),
        .ready(ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int        n;
        logic      rst;
        logic      en;
        logic [3:0]  rq;
        logic      sl;
        logic [12:0] sv;
        logic [3:0]  g;
        logic [12:0] r;
        logic      rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n, logic rst, logic en,
                                logic [3:0] rq, logic sl,
                                logic [12:0] sv, logic [3:0] g,
                                logic [12:0] r, logic rdy);
        vec_t v;
        v.n = n; v.rst = rst; v.en = en; v.rq = rq;
        v.sl = sl; v.sv = sv; v.g = g; v.r = r; v.rdy = rdy;
        return v;
    endfunction

    // Fibonacci step: feedback is parity of taps 12,3,2,0.
    function automatic logic [12:0] nx(logic [12:0] v);
        return {v[11:0], ^(v & 13'h100D)};
    endfunction

    function automatic logic [12:0] lfsr_n(int n);
        logic [12:0] v;
        v = 13'h000F;
        for (int i = 0; i < n; i++) v = nx(v);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: "wait" = shifts still owed before a grant.
    logic [12:0]     m_lfsr;
    int              m_wait;
    int              m_last;
    logic [NREQ-1:0] m_gnt;
    logic [12:0]     m_rnd;

    task automatic m_reset();
        m_lfsr = 13'h000F;
        m_wait = REFRESH;
        m_last = NREQ - 1;
        m_gnt  = '0;
        m_rnd  = 13'h0;
    endtask

    function automatic int pick(logic [NREQ-1:0] r, int last);
`ifdef LFSR_SHARE_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic m_step(logic rs, logic en, logic [NREQ-1:0] r,
                          logic sl, logic [12:0] sv);
        int w;
        m_gnt = '0;
        if (rs) begin
            m_reset();
        end else if (sl) begin
            m_lfsr = (sv == 0) ? 13'h000F : sv;
            m_wait = REFRESH;
        end else if (en) begin
            if (m_wait > 0) begin
                m_wait--;
            end else begin
                w = pick(r, m_last);
                if (w >= 0) begin
                    m_gnt  = NREQ'(1) << w;
                    m_rnd  = m_lfsr;
                    m_last = w;
                    m_wait = REFRESH;
                end
            end
            m_lfsr = nx(m_lfsr);
        end
    endtask

    logic [3:0] eg;

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        req       = '0;
        seed_load = 1'b0;
        seed_val  = 13'h0;

        // n, rst, en, req, sl, sv, gnt, rnd, ready
        tbl.push_back(mk(2, 1, 1, 4'b0100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(12, 0, 1, 4'b0100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 4'b0100, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 4'b0100, 0, 0, 4'b0100, 13'h1FF4, 0));
        tbl.push_back(mk(13, 0, 1, 4'b0000, 0, 0, 0, 13'h1FF4, 1));
        tbl.push_back(mk(1, 0, 1, 4'b0001, 1, 0, 0, 13'h1FF4, 0));
        tbl.push_back(mk(13, 0, 1, 4'b0001, 0, 0, 0, 13'h1FF4, 1));
        tbl.push_back(mk(1, 0, 1, 4'b0001, 0, 0, 4'b0001, 13'h1FF4, 0));
        tbl.push_back(mk(1, 1, 1, 4'b0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5, 0, 1, 4'b0100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5, 0, 0, 4'b0100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7, 0, 1, 4'b0100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 4'b0100, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 4'b0100, 0, 0, 4'b0100, 13'h1FF4, 0));
        tbl.push_back(mk(13, 0, 1, 4'b0000, 0, 0, 0, 13'h1FF4, 1));
        tbl.push_back(mk(3, 0, 0, 4'b0010, 0, 0, 0, 13'h1FF4, 1));
        tbl.push_back(mk(1, 0, 1, 4'b0010, 0, 0, 4'b0010, lfsr_n(27), 0));
        tbl.push_back(mk(1, 0, 1, 4'b0000, 0, 0, 0, lfsr_n(27), 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset     = tbl[i].rst;
            enable    = tbl[i].en;
            req       = tbl[i].rq;
            seed_load = tbl[i].sl;
            seed_val  = tbl[i].sv;
            for (int c = 0; c < tbl[i].n; c++) begin
                tick();
                seed_load = 1'b0;
            end
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].g));
            chk($sformatf("vec%0d_rnd", i), 32'(rnd_out), 32'(tbl[i].r));
            chk($sformatf("vec%0d_rdy", i), 32'(ready), 32'(tbl[i].rdy));
            if (i == 5) begin
                chk("seed_lfsr", 32'(dut.lfsr_q), 32'h000F);
                chk("seed_cnt", 32'(dut.cnt_q), 32'h0);
            end
        end

        // All four requesting: grant order and spacing.
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        req    = 4'b1111;
        for (int c = 1; c <= 70; c++) begin
            tick();
            eg = 4'b0000;
            if (c % 14 == 0) begin
`ifdef LFSR_SHARE_RR_EN
                eg = 4'(1 << ((c / 14 - 1) % 4));
`else
                eg = 4'b0001;
`endif
            end
            chk($sformatf("rr_c%0d", c), 32'(gnt), 32'(eg));
        end

        // Reset one cycle after the last grant.
        tick();
        #2;
        reset = 1'b1;
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rnd", 32'(rnd_out), 32'h0);
        chk("rst_rdy", 32'(ready), 32'h0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'h000F);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 14; c++) tick();
        chk("rst_ptr_gnt", 32'(gnt), 32'h1);
        chk("rst_ptr_rnd", 32'(rnd_out), 32'h1FF4);

        // Randomized run against the model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(7) != 0);
            req       = NREQ'($urandom);
            seed_load = ($urandom_range(63) == 0);
            seed_val  = ($urandom_range(3) == 0) ? 13'h0 : 13'($urandom);
            tick();
            m_step(1'b0, enable, req, seed_load, seed_val);
            chk("rnd_gnt", 32'(gnt), 32'(m_gnt));
            chk("rnd_rnd", 32'(rnd_out), 32'(m_rnd));
            chk("rnd_rdy", 32'(ready), 32'(m_wait == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_share_ctrl.md
# lfsr_share_ctrl

Shares one 13-bit Fibonacci LFSR between up to `NREQ` game-logic requesters (mole placement, delay picker, score jitter, and so on). The block owns the LFSR state and advances it whenever `enable` is high. Between grants it enforces a refresh interval of `REFRESH` shifts, so successive consumers never receive correlated values. Requests are arbitrated, and each grant delivers one registered random word.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, range 2..8.
- `REFRESH`, default 13: minimum LFSR shifts between grants, range 1..15.
- `SEED`, default 13'h000F: LFSR reset value; must be nonzero.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: global run. When low, the LFSR, refresh counter and arbitration all freeze.
- `req` in NREQ: level request per requester. Held high until its `gnt` bit pulses.
- `seed_load` in 1: single-cycle pulse that loads `seed_val`.
- `seed_val` in 13: new LFSR value. A value of 0 is replaced by 13'h000F.
- `gnt` out NREQ: one-hot grant, one-cycle pulse, registered.
- `rnd_out` out 13: random word. Valid in the cycle `gnt` is nonzero; holds its last value otherwise.
- `ready` out 1: high while in READY, meaning the next request will be granted.

## Operation
- LFSR: feedback `fb = lfsr[12]^lfsr[3]^lfsr[2]^lfsr[0]`; shift `lfsr <= {lfsr[11:0], fb}` on every edge with `enable` high and `seed_load` low.
- State register `st` has two states, REFILL and READY. The refresh counter `cnt` is 4 bits.
- REFILL, on each enabled edge:
  - `cnt` increments.
  - When `cnt == REFRESH-1`, go to READY and clear `cnt`.
- READY, on an enabled edge with `req != 0`:
  - Drive `gnt <= onehot(winner)` and `rnd_out <= lfsr` (the pre-shift value).
  - Update the arbitration pointer.
  - Go to REFILL.
- READY with `req == 0`: stay in READY; the LFSR keeps shifting.
- Arbitration: round-robin. The search starts at `ptr`, ascending with wrap. After a grant to index i, `ptr <= (i+1) mod NREQ`.
- If a requester drops `req` before it is granted, nothing is issued to it and there is no error.
- `seed_load` has priority over everything, regardless of `enable`:
  - LFSR takes `seed_val` (or 13'h000F if `seed_val` is 0).
  - `cnt <= 0`, `st <= REFILL`.
  - No grant is issued that cycle, and pending `req` bits remain pending.
  - `ptr` is unchanged.
- `enable` low: no shift, no count, no grant. `gnt` is 0. `rnd_out` holds. State holds.

## Timing
- Reset values:
  - `lfsr = SEED`, `cnt = 0`, `st = REFILL`, `ptr = 0`.
  - `gnt = 0`, `rnd_out = 0`, `ready = 0`.
- With continuous `enable`, the first READY follows `REFRESH` enabled edges after reset release.
- Grant latency from READY with `req` asserted is one edge. `gnt` and `rnd_out` appear after that edge.
- Minimum grant spacing is `REFRESH+1` enabled cycles.
- A requester sees its `gnt` bit for exactly one cycle. It must deassert or re-arm `req` on the cycle after `gnt` to avoid a second grant later.
- Reset asserted mid-operation clears everything immediately. Any in-flight grant is lost.
- `enable` deasserted in READY with `req` high: the grant is deferred to the first enabled edge after re-enable.

## Configuration
- `LFSR_SHARE_RR_EN`:
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority with `req[0]` highest. `ptr` logic is removed and reads as constant 0. All other behaviour is identical.

## Test plan
- Reset with defaults, `enable=1`, `req=4'b0100` held:
  - `ready` rises after edge 13.
  - At edge 14, `gnt = 4'b0100` and `rnd_out = 13'h1FF4`.
  - LFSR sequence from 13'h000F: 001F, 003F, …, 0FFF, 1FFF, 1FFE, 1FFD, 1FFA, 1FF4.
- `req=4'b1111` held, round-robin:
  - Grants go 0001, 0010, 0100, 1000, 0001, spaced exactly 14 cycles apart.
  - With the macro undefined, every grant is 0001.
- `seed_load=1` with `seed_val=0` in the same cycle a grant would occur:
  - No `gnt`.
  - LFSR = 13'h000F, `cnt = 0`, state REFILL.
  - The pending request is granted 14 cycles later with `rnd_out = 13'h1FF4`.
- `enable` dropped for 5 cycles during REFILL:
  - LFSR and `cnt` frozen.
  - The first grant is delayed by exactly 5 cycles; `rnd_out` is unchanged versus the unstalled run.
- `reset` pulsed one cycle after a grant:
  - `gnt`, `rnd_out` and `ready` read 0.
  - LFSR is back to 13'h000F and `ptr` is 0.
